iob_rr_merge: RTL and testbench
===============================

Name: iob_rr_merge

Overview:
- Round-robin arbiter that merges N IOb manager interfaces onto one IOb subordinate interface.
- Grants one manager at a time and holds the grant until that transaction completes: write accept, or read response.
- Steers the subordinate's ready/rvalid/rdata back to the granted manager only.
- Sits between CPU/DMA-style managers and a shared memory or peripheral bus.

Parameters:
- DATA_W, 32, data width per interface; must be a multiple of 8.
- ADDR_W, 32, address width per interface.
- N, 2, number of manager ports; N >= 2.
- NBITS, derived, $clog2(N); width of the grant index.

Ports:
- clk_i  input  1  clock.
- arst_i  input  1  asynchronous reset, active-high.
- cke_i  input  1  clock enable; all registers hold when low.
- avalid_i  input  N  per-manager request valid.
- addr_i  input  N*ADDR_W  per-manager address, manager k in slice [k*ADDR_W +: ADDR_W].
- wdata_i  input  N*DATA_W  per-manager write data.
- wstrb_i  input  N*DATA_W/8  per-manager byte strobes; all zero means a read.
- ready_o  output  N  per-manager request accepted.
- rvalid_o  output  N  per-manager read data valid.
- rdata_o  output  N*DATA_W  per-manager read data.
- avalid_o  output  1  subordinate request valid.
- addr_o  output  ADDR_W  subordinate address.
- wdata_o  output  DATA_W  subordinate write data.
- wstrb_o  output  DATA_W/8  subordinate strobes.
- ready_i  input  1  subordinate accept.
- rvalid_i  input  1  subordinate read data valid.
- rdata_i  input  DATA_W  subordinate read data.
- busy_o  output  1  high in GRANT or RESP.

Behaviour:
- Reset: state=ARB, gnt_idx=0, last_idx=N-1 (manager 0 has top priority first). All outputs are 0.
- cke_i=0: state, gnt_idx and last_idx hold. Combinational outputs still follow the current state.
- ARB state:
  - avalid_o=0; ready_o=0; rvalid_o=0.
  - If any avalid_i bit is set, pick the first set bit searching last_idx+1, last_idx+2, ... with modulo-N wrap.
  - Register the pick into gnt_idx and go to GRANT. The arbitration bubble is exactly 1 cycle.
  - If no avalid_i bit is set, stay in ARB.
- GRANT state:
  - avalid_o=avalid_i[gnt_idx]; addr_o, wdata_o and wstrb_o are the gnt_idx slices.
  - ready_o[gnt_idx]=ready_i; all other ready_o bits are 0.
  - Handshake (avalid_o & ready_i) with wstrb_o!=0 (write): last_idx<=gnt_idx, go to ARB.
  - Handshake with wstrb_o==0 (read): go to RESP.
  - Granted avalid_i drops before a handshake (protocol violation): last_idx<=gnt_idx, go to ARB. No transaction is issued.
  - Non-granted requesters wait; their ready_o stays 0.
- RESP state:
  - avalid_o=0.
  - rvalid_o[gnt_idx]=rvalid_i; rdata_o slice gnt_idx=rdata_i; other rdata_o slices are 0.
  - On rvalid_i: last_idx<=gnt_idx, go to ARB.
  - rvalid_i is ignored outside RESP. The subordinate must return rvalid at least 1 cycle after ready.
- One outstanding transaction at a time. Zero-wait subordinate throughput:
  - write: 1 transaction per 2 cycles;
  - read: 1 per 3 cycles.
- Fairness: after manager k is served, every other requesting manager is served before k again. No starvation.
- Reset mid-transaction returns to ARB immediately. Any pending read response is dropped.

Test Plan:
- N=4, DATA_W=32. Managers 0 and 2 write simultaneously after reset, subordinate ready_i=1 → manager 0 served first (ready_o=4'b0001), then manager 2 (ready_o=4'b0100). Each pair of handshakes is 2 cycles apart.
- All 4 managers hold avalid_i with reads; subordinate returns rdata=0xA0+idx 2 cycles after ready → grant order 0,1,2,3,0. Each manager sees rvalid_o only on its own bit with its own data.
- Manager 1 read of addr 0x40, ready_i delayed 3 cycles, rvalid_i delayed 4 cycles → busy_o stays high throughout. Manager 3's concurrent request is not granted until the cycle after rvalid_i.
- cke_i=0 for 5 cycles in RESP → state holds. The response is delivered only after cke_i returns high.
- arst_i asserted in RESP → outputs 0 next cycle. The first grant after reset goes to manager 0 even if manager 3 was last served.
- Granted manager 2 drops avalid_i in GRANT before ready_i → no subordinate handshake. The arbiter returns to ARB and grants the next requester, manager 3.

Source files
------------

// File: rtl/iob_rr_merge.sv
// Round-robin merge of N IOb manager ports onto one IOb subordinate port.
// One transaction is outstanding at a time; the grant is held until write accept or read response.
//
// state | meaning
// ARB   | no grant; pick the next requester after last_idx (one-cycle bubble)
// GRANT | request of manager gnt_idx forwarded to the subordinate
// RESP  | read accepted; waiting for rvalid_i to return to manager gnt_idx
module iob_rr_merge #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int N      = 2
) (
    input  logic                    clk_i,
    input  logic                    arst_i,
    input  logic                    cke_i,
    input  logic [N-1:0]            avalid_i,
    input  logic [N*ADDR_W-1:0]     addr_i,
    input  logic [N*DATA_W-1:0]     wdata_i,
    input  logic [N*DATA_W/8-1:0]   wstrb_i,
    output logic [N-1:0]            ready_o,
    output logic [N-1:0]            rvalid_o,
    output logic [N*DATA_W-1:0]     rdata_o,
    output logic                    avalid_o,
    output logic [ADDR_W-1:0]       addr_o,
    output logic [DATA_W-1:0]       wdata_o,
    output logic [DATA_W/8-1:0]     wstrb_o,
    input  logic                    ready_i,
    input  logic                    rvalid_i,
    input  logic [DATA_W-1:0]       rdata_i,
    output logic                    busy_o
);

    localparam int NBITS  = $clog2(N);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {ARB, GRANT, RESP} state_t;

    state_t            state;
    logic [NBITS-1:0]  gnt_idx;
    logic [NBITS-1:0]  last_idx;

    logic              pick_found;
    logic [NBITS-1:0]  pick_idx;
    logic [NBITS-1:0]  cand;

    logic              sel_avalid;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [STRB_W-1:0] sel_wstrb;

    // Rotating priority: search starts just after the last manager served.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= N; i++) begin
            cand = NBITS'((int'(last_idx) + i) % N);
            if (!pick_found && avalid_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_avalid = avalid_i[gnt_idx];
        sel_addr   = addr_i[int'(gnt_idx)*ADDR_W +: ADDR_W];
        sel_wdata  = wdata_i[int'(gnt_idx)*DATA_W +: DATA_W];
        sel_wstrb  = wstrb_i[int'(gnt_idx)*STRB_W +: STRB_W];
    end

    always_comb begin
        avalid_o = 1'b0;
        addr_o   = '0;
        wdata_o  = '0;
        wstrb_o  = '0;
        ready_o  = '0;
        rvalid_o = '0;
        rdata_o  = '0;
        case (state)
            GRANT: begin
                avalid_o         = sel_avalid;
                addr_o           = sel_addr;
                wdata_o          = sel_wdata;
                wstrb_o          = sel_wstrb;
                ready_o[gnt_idx] = ready_i;
            end
            RESP: begin
                rvalid_o[gnt_idx]                        = rvalid_i;
                rdata_o[int'(gnt_idx)*DATA_W +: DATA_W] = rdata_i;
            end
            default: ;
        endcase
        busy_o = (state != ARB);
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state    <= ARB;
            gnt_idx  <= '0;
            last_idx <= NBITS'(N - 1);
        end else if (cke_i) begin
            case (state)
                ARB: begin
                    if (pick_found) begin
                        gnt_idx <= pick_idx;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    // A requester that withdraws before acceptance forfeits its turn.
                    if (!sel_avalid) begin
                        last_idx <= gnt_idx;
                        state    <= ARB;
                    end else if (ready_i) begin
                        if (|sel_wstrb) begin
                            last_idx <= gnt_idx;
                            state    <= ARB;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (rvalid_i) begin
                        last_idx <= gnt_idx;
                        state    <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_rr_merge.sv
// Bench for iob_rr_merge with four managers: scripted subordinate timing per scenario,
// and a scoreboard of expected write handshakes and read responses.
module tb_iob_rr_merge;

    localparam int N = 4;
    localparam int DW = 32;
    localparam int AW = 32;

    logic            clk = 1'b0;
    logic            arst = 1'b1;
    logic            cke = 1'b1;
    logic [N-1:0]    avalid = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N*4-1:0]  wstrb = '0;
    logic [N-1:0]    ready_o, rvalid_o;
    logic [N*DW-1:0] rdata_o;
    logic            avalid_o;
    logic [AW-1:0]   addr_o;
    logic [DW-1:0]   wdata_o;
    logic [3:0]      wstrb_o;
    logic            ready_i = 1'b0;
    logic            rvalid_i = 1'b0;
    logic [DW-1:0]   rdata_i = '0;
    logic            busy_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } exp_t;

    exp_t wr_q[$];
    exp_t rd_q[$];
    exp_t mon_e;
    int   mon_idx;
    logic mon_bad;

    iob_rr_merge #(.DATA_W(DW), .ADDR_W(AW), .N(N)) dut (
        .clk_i(clk), .arst_i(arst), .cke_i(cke),
        .avalid_i(avalid), .addr_i(addr), .wdata_i(wdata), .wstrb_i(wstrb),
        .ready_o(ready_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .avalid_o(avalid_o), .addr_o(addr_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
        .ready_i(ready_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Scoreboard: write handshakes and delivered read data, sampled mid-cycle.
    always @(negedge clk) begin
        if (!arst && cke && avalid_o && ready_i && wstrb_o != 4'h0) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: handshake addr %h data %h, none expected", addr_o, wdata_o);
            end else begin
                mon_e = wr_q.pop_front();
                mon_idx = -1;
                for (int k = 0; k < N; k++)
                    if (ready_o[k]) mon_idx = (mon_idx == -1) ? k : -2;
                if (mon_idx !== mon_e.idx || addr_o !== mon_e.addr || wdata_o !== mon_e.data || wstrb_o !== mon_e.strb) begin
                    errors++;
                    $display("FAIL wr_txn: got mgr %0d addr %h data %h strb %h, want mgr %0d addr %h data %h strb %h",
                             mon_idx, addr_o, wdata_o, wstrb_o, mon_e.idx, mon_e.addr, mon_e.data, mon_e.strb);
                end
            end
        end
        if (!arst && cke && rvalid_o != '0) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: rvalid_o %b, none expected", rvalid_o);
            end else begin
                mon_e = rd_q.pop_front();
                mon_bad = (rvalid_o !== 4'(1 << mon_e.idx)) || (rdata_o[mon_e.idx*DW +: DW] !== mon_e.data);
                for (int k = 0; k < N; k++)
                    if (k != mon_e.idx && rdata_o[k*DW +: DW] !== '0) mon_bad = 1'b1;
                if (mon_bad) begin
                    errors++;
                    $display("FAIL rd_resp: got rvalid %b rdata %h, want mgr %0d data %h",
                             rvalid_o, rdata_o, mon_e.idx, mon_e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        avalid[k] = 1'b1;
        addr[k*AW +: AW] = a;
        wdata[k*DW +: DW] = d;
        wstrb[k*4 +: 4] = s;
    endtask

    task automatic drop(input int k);
        avalid[k] = 1'b0;
    endtask

    task automatic push_wr(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        e.idx = k; e.addr = a; e.data = d; e.strb = s;
        wr_q.push_back(e);
    endtask

    task automatic push_rd(input int k, input logic [31:0] d);
        exp_t e;
        e.idx = k; e.addr = '0; e.data = d; e.strb = '0;
        rd_q.push_back(e);
    endtask

    task automatic reset_dut();
        avalid = '0; addr = '0; wdata = '0; wstrb = '0;
        ready_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; cke = 1'b1;
        arst = 1'b1;
        tick();
        tick();
        arst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        arst = 1'b1;
        tick();
        checks++;
        if (busy_o !== 1'b0 || avalid_o !== 1'b0 || ready_o !== '0 || rvalid_o !== '0 ||
            rdata_o !== '0 || addr_o !== '0 || wdata_o !== '0 || wstrb_o !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy %b avalid %b ready %b rvalid %b addr %h, want all 0",
                     busy_o, avalid_o, ready_o, rvalid_o, addr_o);
        end
        reset_dut();
    endtask

    task automatic test_write_pair();
        reset_dut();
        req(0, 32'h100, 32'h1111_1111, 4'hF);
        req(2, 32'h200, 32'h2222_2222, 4'h3);
        ready_i = 1'b1;
        push_wr(0, 32'h100, 32'h1111_1111, 4'hF);
        push_wr(2, 32'h200, 32'h2222_2222, 4'h3);
        #1;
        checks++;
        if (busy_o !== 1'b0 || ready_o !== 4'b0000) begin
            errors++; $display("FAIL wp_arb: busy %b ready %b, want 0 0000", busy_o, ready_o);
        end
        tick();
        checks++;
        if (ready_o !== 4'b0001 || busy_o !== 1'b1) begin
            errors++; $display("FAIL wp_grant0: ready %b busy %b, want 0001 1", ready_o, busy_o);
        end
        tick();
        drop(0);
        #1;
        checks++;
        if (ready_o !== 4'b0000 || busy_o !== 1'b0) begin
            errors++; $display("FAIL wp_bubble: ready %b busy %b, want 0000 0", ready_o, busy_o);
        end
        tick();
        checks++;
        if (ready_o !== 4'b0100) begin
            errors++; $display("FAIL wp_grant2: ready %b, want 0100", ready_o);
        end
        tick();
        drop(2);
        ready_i = 1'b0;
        #1;
    endtask

    task automatic test_read_rr();
        logic [3:0] exp_oh;
        int e;
        reset_dut();
        for (int k = 0; k < N; k++) req(k, 32'h10 * k, 32'h0, 4'h0);
        ready_i = 1'b1;
        for (int j = 0; j < 5; j++) begin
            e = j % N;
            exp_oh = 4'(1 << e);
            push_rd(e, 32'hA0 + e);
            tick();
            checks++;
            if (ready_o !== exp_oh || addr_o !== 32'(32'h10 * e)) begin
                errors++; $display("FAIL rr_grant%0d: ready %b addr %h, want %b %h", j, ready_o, addr_o, exp_oh, 32'h10 * e);
            end
            tick();
            checks++;
            if (rvalid_o !== 4'b0000 || busy_o !== 1'b1 || avalid_o !== 1'b0) begin
                errors++; $display("FAIL rr_wait%0d: rvalid %b busy %b avalid %b, want 0000 1 0", j, rvalid_o, busy_o, avalid_o);
            end
            tick();
            rvalid_i = 1'b1;
            rdata_i = 32'hA0 + e;
            #1;
            checks++;
            if (rvalid_o !== exp_oh) begin
                errors++; $display("FAIL rr_rvalid%0d: rvalid %b, want %b", j, rvalid_o, exp_oh);
            end
            tick();
            rvalid_i = 1'b0;
            if (j == 4) avalid = '0;
            #1;
        end
        ready_i = 1'b0;
    endtask

    task automatic test_delayed();
        reset_dut();
        req(1, 32'h40, 32'h0, 4'h0);
        req(3, 32'h300, 32'h3333_3333, 4'hF);
        #1;
        tick();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (busy_o !== 1'b1 || avalid_o !== 1'b1 || addr_o !== 32'h40 || ready_o !== 4'b0000) begin
                errors++; $display("FAIL dl_grant_wait%0d: busy %b avalid %b addr %h ready %b, want 1 1 40 0000",
                                   c, busy_o, avalid_o, addr_o, ready_o);
            end
            tick();
        end
        ready_i = 1'b1;
        push_rd(1, 32'hBEEF_0040);
        #1;
        checks++;
        if (ready_o !== 4'b0010) begin
            errors++; $display("FAIL dl_accept: ready %b, want 0010", ready_o);
        end
        tick();
        ready_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin
                rvalid_i = 1'b1;
                rdata_i = 32'hBEEF_0040;
            end
            #1;
            checks++;
            if (busy_o !== 1'b1 || ready_o !== 4'b0000) begin
                errors++; $display("FAIL dl_resp_wait%0d: busy %b ready %b, want 1 0000", c, busy_o, ready_o);
            end
            tick();
        end
        rvalid_i = 1'b0;
        drop(1);
        #1;
        checks++;
        if (busy_o !== 1'b0 || ready_o !== 4'b0000) begin
            errors++; $display("FAIL dl_m3_held: busy %b ready %b, want 0 0000", busy_o, ready_o);
        end
        tick();
        ready_i = 1'b1;
        push_wr(3, 32'h300, 32'h3333_3333, 4'hF);
        #1;
        checks++;
        if (ready_o !== 4'b1000) begin
            errors++; $display("FAIL dl_m3_grant: ready %b, want 1000", ready_o);
        end
        tick();
        drop(3);
        ready_i = 1'b0;
        #1;
    endtask

    task automatic test_cke();
        reset_dut();
        req(0, 32'h500, 32'h0, 4'h0);
        ready_i = 1'b1;
        cke = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (busy_o !== 1'b0) begin
                errors++; $display("FAIL cke_arb_hold%0d: busy %b, want 0", c, busy_o);
            end
        end
        cke = 1'b1;
        push_rd(0, 32'hCAFE_0001);
        tick();
        checks++;
        if (ready_o !== 4'b0001) begin
            errors++; $display("FAIL cke_grant: ready %b, want 0001", ready_o);
        end
        tick();
        ready_i = 1'b0;
        drop(0);
        cke = 1'b0;
        rvalid_i = 1'b1;
        rdata_i = 32'hCAFE_0001;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (busy_o !== 1'b1) begin
                errors++; $display("FAIL cke_resp_hold%0d: busy %b, want 1", c, busy_o);
            end
        end
        cke = 1'b1;
        #1;
        checks++;
        if (rvalid_o !== 4'b0001) begin
            errors++; $display("FAIL cke_deliver: rvalid %b, want 0001", rvalid_o);
        end
        tick();
        rvalid_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL cke_done: busy %b, want 0", busy_o);
        end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        req(1, 32'h610, 32'h6161_6161, 4'hF);
        ready_i = 1'b1;
        push_wr(1, 32'h610, 32'h6161_6161, 4'hF);
        tick();
        tick();
        drop(1);
        req(3, 32'h630, 32'h0, 4'h0);
        tick();
        checks++;
        if (ready_o !== 4'b1000) begin
            errors++; $display("FAIL rm_grant3: ready %b, want 1000", ready_o);
        end
        tick();
        ready_i = 1'b0;
        rvalid_i = 1'b1;
        rdata_i = 32'hDEAD_0003;
        arst = 1'b1;
        #1;
        checks++;
        if (busy_o !== 1'b0 || rvalid_o !== '0 || ready_o !== '0 || avalid_o !== 1'b0 || rdata_o !== '0) begin
            errors++; $display("FAIL rm_async: busy %b rvalid %b ready %b avalid %b, want all 0", busy_o, rvalid_o, ready_o, avalid_o);
        end
        tick();
        checks++;
        if (busy_o !== 1'b0 || rvalid_o !== '0) begin
            errors++; $display("FAIL rm_next: busy %b rvalid %b, want 0 0000", busy_o, rvalid_o);
        end
        arst = 1'b0;
        rvalid_i = 1'b0;
        drop(3);
        req(0, 32'h600, 32'h6060_6060, 4'h1);
        req(2, 32'h620, 32'h6262_6262, 4'h8);
        ready_i = 1'b1;
        push_wr(0, 32'h600, 32'h6060_6060, 4'h1);
        push_wr(2, 32'h620, 32'h6262_6262, 4'h8);
        tick();
        checks++;
        if (ready_o !== 4'b0001) begin
            errors++; $display("FAIL rm_first_grant: ready %b, want 0001", ready_o);
        end
        tick();
        drop(0);
        tick();
        checks++;
        if (ready_o !== 4'b0100) begin
            errors++; $display("FAIL rm_second_grant: ready %b, want 0100", ready_o);
        end
        tick();
        drop(2);
        ready_i = 1'b0;
        #1;
    endtask

    task automatic test_drop();
        reset_dut();
        req(1, 32'h710, 32'h7171_7171, 4'hF);
        ready_i = 1'b1;
        push_wr(1, 32'h710, 32'h7171_7171, 4'hF);
        tick();
        tick();
        drop(1);
        ready_i = 1'b0;
        req(2, 32'h720, 32'h7272_7272, 4'hF);
        req(3, 32'h730, 32'h7373_7373, 4'hC);
        tick();
        checks++;
        if (avalid_o !== 1'b1 || addr_o !== 32'h720 || ready_o !== 4'b0000) begin
            errors++; $display("FAIL dr_grant2: avalid %b addr %h ready %b, want 1 720 0000", avalid_o, addr_o, ready_o);
        end
        drop(2);
        #1;
        checks++;
        if (avalid_o !== 1'b0) begin
            errors++; $display("FAIL dr_withdrawn: avalid %b, want 0", avalid_o);
        end
        tick();
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL dr_back_to_arb: busy %b, want 0", busy_o);
        end
        tick();
        ready_i = 1'b1;
        push_wr(3, 32'h730, 32'h7373_7373, 4'hC);
        #1;
        checks++;
        if (ready_o !== 4'b1000 || addr_o !== 32'h730) begin
            errors++; $display("FAIL dr_grant3: ready %b addr %h, want 1000 730", ready_o, addr_o);
        end
        tick();
        drop(3);
        ready_i = 1'b0;
        #1;
    endtask

    initial begin
        test_reset();
        test_write_pair();
        test_read_rr();
        test_delayed();
        test_cke();
        test_reset_mid();
        test_drop();
        tick();
        tick();
        checks++;
        if (wr_q.size() != 0 || rd_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d writes and %0d reads never seen, want 0 0", wr_q.size(), rd_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
